// File: rtl/add_seq_pkg.sv
// Shared types and default sizes for the operand-accumulation sequencer.
package add_seq_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned COUNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } add_seq_state_e;

endpackage : add_seq_pkg

// File: rtl/add_accum_sequencer_adder.sv
// Shared ripple/carry-chain adder; the carry-out is the top bit of sum_o.
module adder #(
    parameter int unsigned width_p = 32
) (
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic [width_p:0]   sum_o
);

    // Unsigned add with carry-out kept in the extra bit.
    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule : adder

// File: rtl/add_accum_sequencer.sv
// Sums a command-specified number of streamed operands through the shared adder
// and returns the sum plus a sticky carry flag.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a command (operand count)
// ACCUM | accepting operands, one per cycle, until the count is used
// DONE  | holding the result until the consumer takes it
module add_accum_sequencer
    import add_seq_pkg::*;
#(
    parameter int unsigned width_p   = WIDTH_DEF,
    parameter int unsigned count_w_p = COUNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 cmd_valid_i,
    input  logic [count_w_p-1:0] cmd_count_i,
    output logic                 cmd_ready_o,
    input  logic                 op_valid_i,
    input  logic [width_p-1:0]   op_data_i,
    output logic                 op_ready_o,
    output logic                 res_valid_o,
    output logic [width_p-1:0]   res_data_o,
    output logic                 res_carry_o,
    input  logic                 res_ready_i
);

    add_seq_state_e       state_q, state_d;
    logic [width_p-1:0]   acc_q, acc_d;
    logic                 carry_q, carry_d;
    logic [count_w_p-1:0] rem_q, rem_d;
    logic [width_p:0]     sum;

    adder #(.width_p(width_p)) u_adder (
        .a_i   (acc_q),
        .b_i   (op_data_i),
        .sum_o (sum)
    );

    // State, accumulator, sticky carry and remaining-operand count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic and handshake generation.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        rem_d       = rem_q;
        cmd_ready_o = 1'b0;
        op_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    rem_d   = cmd_count_i;
                    state_d = (cmd_count_i == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    acc_d   = sum[width_p-1:0];
                    carry_d = carry_q | sum[width_p];
                    rem_d   = rem_q - count_w_p'(1);
                    if (rem_q == count_w_p'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result fields read as zero whenever no result is offered.
    assign res_data_o  = res_valid_o ? acc_q : '0;
    assign res_carry_o = res_valid_o & carry_q;

endmodule : add_accum_sequencer

// File: tb/tb_add_accum_sequencer.sv
module tb_add_accum_sequencer;

    localparam int W  = 32;
    localparam int CW = 8;
    localparam int TMO = 50;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          cmd_valid_i;
    logic [CW-1:0] cmd_count_i;
    logic          cmd_ready_o;
    logic          op_valid_i;
    logic [W-1:0]  op_data_i;
    logic          op_ready_o;
    logic          res_valid_o;
    logic [W-1:0]  res_data_o;
    logic          res_carry_o;
    logic          res_ready_i;

    int n_cmp = 0;
    int n_err = 0;
    int n_res = 0;
    logic [W:0] sb_q[$];

    add_accum_sequencer #(.width_p(W), .count_w_p(CW)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_count_i (cmd_count_i),
        .cmd_ready_o (cmd_ready_o),
        .op_valid_i  (op_valid_i),
        .op_data_i   (op_data_i),
        .op_ready_o  (op_ready_o),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_carry_o (res_carry_o),
        .res_ready_i (res_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    always @(negedge clk_i) begin
        if (!reset_i && res_valid_o && res_ready_i) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %h carry %b expected none", res_data_o, res_carry_o);
            end else begin
                logic [W:0] e;
                e = sb_q.pop_front();
                chk("res_data", 64'(res_data_o), 64'(e[W-1:0]));
                chk("res_carry", 64'(res_carry_o), 64'(e[W]));
                n_res++;
            end
        end
    end

    task automatic send_cmd(input logic [CW-1:0] cnt);
        int t = 0;
        cmd_valid_i = 1'b1;
        cmd_count_i = cnt;
        forever begin
            @(negedge clk_i);
            if (cmd_ready_o) break;
            t++;
            if (t > TMO) begin
                chk("cmd_timeout", 64'(cmd_ready_o), 64'd1);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic send_op(input logic [W-1:0] d);
        int t = 0;
        op_valid_i = 1'b1;
        op_data_i  = d;
        forever begin
            @(negedge clk_i);
            if (op_ready_o) break;
            t++;
            if (t > TMO) begin
                chk("op_timeout", 64'(op_ready_o), 64'd1);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i     = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_count_i = '0;
        op_valid_i  = 1'b0;
        op_data_i   = '0;
        res_ready_i = 1'b1;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_op_ready", 64'(op_ready_o), 64'd0);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_res_data", 64'(res_data_o), 64'd0);
        chk("rst_res_carry", 64'(res_carry_o), 64'd0);
        idle_cycles(2);
        reset_i = 1'b0;
        idle_cycles(1);

        // 1: three operands back-to-back, result one cycle after the last
        sb_q.push_back({1'b0, 32'd6});
        send_cmd(8'd3);
        op_valid_i = 1'b1;
        op_data_i  = 32'd1;
        @(posedge clk_i); #1;
        op_data_i  = 32'd2;
        @(posedge clk_i); #1;
        op_data_i  = 32'd3;
        @(posedge clk_i); #1;
        op_valid_i = 1'b0;
        @(negedge clk_i);
        chk("t1_latency_valid", 64'(res_valid_o), 64'd1);
        idle_cycles(2);

        // 2: wrap-around sets the sticky carry
        sb_q.push_back({1'b1, 32'h0000_0001});
        send_cmd(8'd2);
        send_op(32'hFFFF_FFFF);
        send_op(32'h0000_0002);
        idle_cycles(2);

        // 3: zero-count command yields an immediate zero result
        sb_q.push_back({1'b0, 32'd0});
        send_cmd(8'd0);
        @(negedge clk_i);
        chk("t3_valid_next", 64'(res_valid_o), 64'd1);
        chk("t3_no_op_ready", 64'(op_ready_o), 64'd0);
        idle_cycles(2);

        // 4: operand gaps, stray command in ACCUM, 5-cycle result stall
        res_ready_i = 1'b0;
        sb_q.push_back({1'b0, 32'h33});
        send_cmd(8'd2);
        cmd_valid_i = 1'b1;
        cmd_count_i = 8'd9;
        idle_cycles(3);
        chk("t4_gap_op_ready", 64'(op_ready_o), 64'd1);
        chk("t4_accum_cmd_ready", 64'(cmd_ready_o), 64'd0);
        send_op(32'h11);
        idle_cycles(3);
        send_op(32'h22);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("t4_stall_valid", 64'(res_valid_o), 64'd1);
            chk("t4_stall_data", 64'(res_data_o), 64'h33);
            chk("t4_stall_cmd_ready", 64'(cmd_ready_o), 64'd0);
        end
        cmd_valid_i = 1'b0;
        @(posedge clk_i); #1;
        res_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("t4_after_valid", 64'(res_valid_o), 64'd0);
        chk("t4_after_cmd_ready", 64'(cmd_ready_o), 64'd1);
        idle_cycles(1);

        // 5: reset mid-ACCUM discards the partial sum
        send_cmd(8'd3);
        send_op(32'h10);
        reset_i = 1'b1;
        #1;
        chk("t5_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("t5_rst_op_ready", 64'(op_ready_o), 64'd0);
        chk("t5_rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("t5_rst_res_data", 64'(res_data_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        idle_cycles(1);
        sb_q.push_back({1'b0, 32'h5});
        send_cmd(8'd1);
        send_op(32'h5);
        idle_cycles(2);

        // 6: operand offered in IDLE is never consumed
        op_valid_i = 1'b1;
        op_data_i  = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t6_idle_op_ready", 64'(op_ready_o), 64'd0);
        end
        @(posedge clk_i); #1;
        op_valid_i = 1'b0;
        sb_q.push_back({1'b0, 32'h7});
        send_cmd(8'd1);
        send_op(32'h7);
        idle_cycles(2);

        // 7: maximum count, 255 x 0xFFFFFFFF = -255 mod 2**32
        sb_q.push_back({1'b1, 32'hFFFF_FF01});
        send_cmd(8'd255);
        op_valid_i = 1'b1;
        op_data_i  = 32'hFFFF_FFFF;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk_i);
            chk("t7_op_ready", 64'(op_ready_o), 64'd1);
            @(posedge clk_i); #1;
        end
        op_valid_i = 1'b0;
        idle_cycles(3);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("results_seen", 64'(n_res), 64'd7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_add_accum_sequencer
